// File: rtl/clint_timer_if.sv
// clint_timer_if: LSU data-port bus between the load/store unit and the CLINT.
interface clint_timer_if #(parameter int CPU_WIDTH = 32);
  logic ren;
  logic wen;
  logic hit;
  logic rvalid;
  logic [CPU_WIDTH-1:0] addr;
  logic [CPU_WIDTH-1:0] wdata;
  logic [CPU_WIDTH-1:0] rdata;
  logic [3:0] wmask;
  modport master (output ren, wen, addr, wdata, wmask, input rdata, rvalid, hit);
  modport slave (input ren, wen, addr, wdata, wmask, output rdata, rvalid, hit);
endinterface

// File: rtl/clint_timer.sv
// clint_timer: machine-level CLINT with mtime, mtimecmp and msip, driving mip.MTIP/MSIP.
module clint_timer #(
  parameter int CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] BASE_ADDR = 32'h0200_0000,
  parameter int PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  clint_timer_if.slave bus,
  output logic o_mtip,
  output logic o_msip
);
  localparam int W = CPU_WIDTH;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_q, pre_d;
  logic [2*W-1:0] mtime_q, mtime_d, cmp_q, cmp_d;
  logic [W-1:0] rdata_q, rdata_d, rsel;
  logic msip_q, msip_d, mtip_q, mtip_d, rvalid_q, rvalid_d;
  logic [15:0] off;
  logic wr, tick;
  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] wd, input logic [3:0] m);
    merge = old;
    for (int i = 0; i < 4; i++)
      if (m[i]) merge[8*i +: 8] = wd[8*i +: 8];
  endfunction
  assign bus.hit = bus.addr[W-1:16] == BASE_ADDR[W-1:16];
  always_comb begin
    off = bus.addr[15:0];
    wr = bus.wen && bus.hit;
    tick = pre_q == PW'(PRESCALE - 1);
    pre_d = tick ? '0 : pre_q + 1'b1;
    // a write to either mtime half replaces that cycle's increment
    mtime_d = wr && off == 16'hBFF8 ? {mtime_q[2*W-1:W], merge(mtime_q[W-1:0], bus.wdata, bus.wmask)}
            : wr && off == 16'hBFFC ? {merge(mtime_q[2*W-1:W], bus.wdata, bus.wmask), mtime_q[W-1:0]}
            : tick ? mtime_q + 1'b1 : mtime_q;
    cmp_d = wr && off == 16'h4000 ? {cmp_q[2*W-1:W], merge(cmp_q[W-1:0], bus.wdata, bus.wmask)}
          : wr && off == 16'h4004 ? {merge(cmp_q[2*W-1:W], bus.wdata, bus.wmask), cmp_q[W-1:0]}
          : cmp_q;
    msip_d = wr && off == 16'h0000 && bus.wmask[0] ? bus.wdata[0] : msip_q;
    rsel = !bus.hit ? '0
         : off == 16'h0000 ? {{(W-1){1'b0}}, msip_q}
         : off == 16'h4000 ? cmp_q[W-1:0]
         : off == 16'h4004 ? cmp_q[2*W-1:W]
         : off == 16'hBFF8 ? mtime_q[W-1:0]
         : off == 16'hBFFC ? mtime_q[2*W-1:W]
         : '0;
    rdata_d = bus.ren ? rsel : rdata_q;
    rvalid_d = bus.ren;
    mtip_d = mtime_q >= cmp_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre_q <= '0;
      mtime_q <= '0;
      cmp_q <= '1;
      msip_q <= 1'b0;
      mtip_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      pre_q <= pre_d;
      mtime_q <= mtime_d;
      cmp_q <= cmp_d;
      msip_q <= msip_d;
      mtip_q <= mtip_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.rdata = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign o_mtip = mtip_q;
  assign o_msip = msip_q;
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: directed checks of a PRESCALE=1 and a PRESCALE=4 CLINT.
module tb_clint_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  logic mtip1, msip1, mtip4, msip4;
  int passed = 0;
  int fails = 0;
  int total = 0;
  logic [31:0] exp4 [6] = '{32'd1, 32'd2, 32'd2, 32'd2, 32'd2, 32'd3};
  clint_timer_if b1 ();
  clint_timer_if b4 ();
  clint_timer #(.PRESCALE(1)) u1 (.i_clk(clk), .i_rst(rst), .bus(b1), .o_mtip(mtip1), .o_msip(msip1));
  clint_timer #(.PRESCALE(4)) u4 (.i_clk(clk), .i_rst(rst4), .bus(b4), .o_mtip(mtip4), .o_msip(msip4));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic cyc(input bit s, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    if (s) begin
      b4.ren = r; b4.wen = w; b4.addr = a; b4.wdata = d; b4.wmask = m;
    end else begin
      b1.ren = r; b1.wen = w; b1.addr = a; b1.wdata = d; b1.wmask = m;
    end
    step();
    b1.ren = 1'b0; b1.wen = 1'b0; b4.ren = 1'b0; b4.wen = 1'b0;
  endtask
  initial begin
    b1.ren = 0; b1.wen = 0; b1.addr = 0; b1.wdata = 0; b1.wmask = 0;
    b4.ren = 0; b4.wen = 0; b4.addr = 0; b4.wdata = 0; b4.wmask = 0;
    repeat (3) step();
    chk("rst_rvalid", b1.rvalid, 0);
    chk("rst_rdata", b1.rdata, 0);
    chk("rst_mtip", mtip1, 0);
    chk("rst_msip", msip1, 0);
    rst = 1'b0;
    repeat (10) step();
    chk("idle_mtip", mtip1, 0);
    cyc(0, 1, 0, 32'h0200_BFF8, 0, 0);
    chk("idle_rvalid", b1.rvalid, 1);
    chk("idle_mtime", b1.rdata, 10);
    step();
    chk("noread_rvalid", b1.rvalid, 0);
    chk("noread_hold", b1.rdata, 10);
    b1.addr = 32'h0201_0000;
    #1 chk("hit_out", b1.hit, 0);
    b1.addr = 32'h0200_FFFC;
    #1 chk("hit_in", b1.hit, 1);
    cyc(0, 1, 0, 32'h1000_0000, 0, 0);
    chk("miss_rvalid", b1.rvalid, 1);
    chk("miss_rdata", b1.rdata, 0);
    cyc(0, 0, 1, 32'h0200_BFFC, 32'hFFFF_FFFF, 4'hF);
    cyc(0, 0, 1, 32'h0200_BFF8, 32'hFFFF_FFFE, 4'hF);
    cyc(0, 1, 0, 32'h0200_BFF8, 0, 0);
    chk("wr_noinc", b1.rdata, 32'hFFFF_FFFE);
    chk("wrap_mtip0", mtip1, 0);
    cyc(0, 1, 0, 32'h0200_BFFC, 0, 0);
    chk("wrap_hi_pre", b1.rdata, 32'hFFFF_FFFF);
    chk("wrap_mtip1", mtip1, 1);
    cyc(0, 1, 0, 32'h0200_BFFC, 0, 0);
    chk("wrap_hi", b1.rdata, 0);
    chk("wrap_mtip_fall", mtip1, 0);
    cyc(0, 1, 0, 32'h0200_BFF8, 0, 0);
    chk("wrap_lo", b1.rdata, 1);
    cyc(0, 0, 1, 32'h0200_4000, 32'hAABB_CCDD, 4'b0101);
    cyc(0, 1, 0, 32'h0200_4000, 0, 0);
    chk("mask_lo", b1.rdata, 32'hFFBB_FFDD);
    cyc(0, 1, 0, 32'h0200_4004, 0, 0);
    chk("mask_hi", b1.rdata, 32'hFFFF_FFFF);
    cyc(0, 0, 1, 32'h0200_4004, 0, 4'hF);
    cyc(0, 0, 1, 32'h0200_4000, 32'd20, 4'hF);
    cyc(0, 0, 1, 32'h0200_BFF8, 0, 4'hF);
    repeat (20) step();
    chk("cmp_before", mtip1, 0);
    step();
    chk("cmp_rise", mtip1, 1);
    cyc(0, 1, 1, 32'h0200_4000, 32'd1000, 4'hF);
    chk("rdw_old", b1.rdata, 20);
    chk("cmp_hold", mtip1, 1);
    step();
    chk("cmp_fall", mtip1, 0);
    cyc(0, 0, 1, 32'h0200_0000, 32'hFFFF_FFFF, 4'hF);
    chk("msip_set", msip1, 1);
    cyc(0, 1, 0, 32'h0200_0000, 0, 0);
    chk("msip_rd", b1.rdata, 1);
    cyc(0, 0, 1, 32'h0200_0000, 0, 4'hF);
    chk("msip_clr", msip1, 0);
    cyc(0, 0, 1, 32'h0200_0000, 32'h1, 4'b1110);
    chk("msip_masked", msip1, 0);
    cyc(0, 1, 0, 32'h0200_0008, 0, 0);
    chk("hole_rvalid", b1.rvalid, 1);
    chk("hole_rdata", b1.rdata, 0);
    rst4 = 1'b0;
    repeat (7) step();
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 0, 32'h0200_BFF8, 0, 0);
      chk($sformatf("pre4_%0d", i), b4.rdata, exp4[i]);
    end
    cyc(1, 0, 1, 32'h0200_4004, 0, 4'hF);
    cyc(1, 0, 1, 32'h0200_4000, 0, 4'hF);
    step();
    chk("pre4_mtip", mtip4, 1);
    cyc(1, 1, 0, 32'h0200_BFF8, 0, 0);
    chk("pre4_rvalid", b4.rvalid, 1);
    rst4 = 1'b1;
    b4.ren = 1'b1;
    step();
    chk("rst_mid_rvalid", b4.rvalid, 0);
    chk("rst_mid_mtip", mtip4, 0);
    chk("rst_mid_rdata", b4.rdata, 0);
    rst4 = 1'b0;
    b4.ren = 1'b0;
    cyc(1, 1, 0, 32'h0200_BFF8, 0, 0);
    chk("rst_mid_mtime", b4.rdata, 0);
    chk("rst_mid_rv1", b4.rvalid, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
